// File: rtl/clct_sel_pkg.sv
// ---------------------------------------------------------------------------
// clct_sel_pkg
//   Shared definitions for the CLCT window-select stage.
//   - FSM state encoding (IDLE, COLLECT, PUSH, DEAD), 2-bit legacy constants
//   - Field widths for the window index and the priority
//   - Candidate record carried from collection to the output registers
//   - Hit qualification helper, shared so every user applies the same rule
// ---------------------------------------------------------------------------
package clct_sel_pkg;

  // Width of the best-window index coming from the 16-position encoder
  localparam int MXWIN = 4;

  // Width of the window priority
  localparam int MXPRI = 4;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PUSH    = 2'd2;
  localparam logic [1:0] ST_DEAD    = 2'd3;

  // One candidate: its priority, its window index and the clock offset
  // inside the collection window where it was captured
  typedef struct packed {
    logic [MXPRI-1:0] pri;
    logic [MXWIN-1:0] win;
    logic [2:0]       bx;
  } cand_t;

  // A hit needs the block enabled and a priority that is non-zero and at
  // or above the threshold. The explicit non-zero test keeps a threshold
  // of 0 from letting empty windows through.
  function automatic logic is_hit(input logic             enable,
                                  input logic [MXPRI-1:0] pri,
                                  input logic [MXPRI-1:0] thresh);
    return enable && (pri != '0) && (pri >= thresh);
  endfunction

endpackage

// File: rtl/clct_drop_counter.sv
// ---------------------------------------------------------------------------
// clct_drop_counter
//   Saturating event counter with a synchronous clear that has priority over
//   the increment.
//   Ports:
//     clock        design clock
//     global_reset asynchronous active-high reset, clears the count
//     clr          synchronous clear (wins over inc on the same clock)
//     inc          count one event this clock
//     cnt          current count, sticks at all-ones
// ---------------------------------------------------------------------------
module clct_drop_counter #(
  parameter int MXDROP = 8
) (
  input  logic              clock,
  input  logic              global_reset,
  input  logic              clr,
  input  logic              inc,
  output logic [MXDROP-1:0] cnt
);

  // The counter holds at all-ones so that a long burst of drops can never
  // wrap around and look like a quiet period. A clear on the same clock as
  // an event leaves the count at zero; the event is deliberately lost so the
  // reader gets a clean starting point.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clct_window_select.sv
// ---------------------------------------------------------------------------
// clct_window_select
//   Sits right after the 16-position best-window tree encoder. A qualifying
//   hit opens a collection window of WIN_BX clocks; the highest-priority
//   candidate seen in that window is then offered downstream on a
//   valid/ready handshake, followed by a programmable dead time. Hits that
//   arrive while the block cannot take them are counted as drops.
//   Ports:
//     clock          design clock
//     global_reset   asynchronous active-high reset
//     enable         block enable; low aborts whatever is in progress
//     pri_thresh     minimum priority that counts as a hit
//     dead_time      dead clocks after a handshake (sampled at handshake)
//     clct_win_best  best window index from the encoder
//     clct_pri_best  priority of that window
//     out_rdy        downstream ready
//     out_vld        winner valid
//     out_win        winner window index
//     out_pri        winner priority
//     out_bx         clock offset of the winner inside its window
//     busy           high whenever the FSM is not idle
//     drop_clr       synchronous clear of drop_cnt
//     drop_cnt       saturating count of dropped hits
// ---------------------------------------------------------------------------
module clct_window_select
  import clct_sel_pkg::*;
#(
  parameter int WIN_BX = 3,
  parameter int MXDEAD = 4,
  parameter int MXDROP = 8
) (
  input  logic              clock,
  input  logic              global_reset,
  input  logic              enable,
  input  logic [MXPRI-1:0]  pri_thresh,
  input  logic [MXDEAD-1:0] dead_time,
  input  logic [MXWIN-1:0]  clct_win_best,
  input  logic [MXPRI-1:0]  clct_pri_best,
  input  logic              out_rdy,
  output logic              out_vld,
  output logic [MXWIN-1:0]  out_win,
  output logic [MXPRI-1:0]  out_pri,
  output logic [2:0]        out_bx,
  output logic              busy,
  input  logic              drop_clr,
  output logic [MXDROP-1:0] drop_cnt
);

  // Offset of the last clock of the collection window
  localparam logic [2:0]        LAST_BX  = 3'(WIN_BX - 1);
  localparam logic [MXDEAD-1:0] DEAD_ONE = MXDEAD'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  cand_t             best;
  cand_t             best_nxt;
  logic [2:0]        bx_cnt;
  logic [2:0]        bx_cnt_nxt;
  logic [MXDEAD-1:0] dead_cnt;
  logic [MXDEAD-1:0] dead_cnt_nxt;
  logic              hit;
  logic              handshake;
  logic              drop;

  assign hit       = is_hit(enable, clct_pri_best, pri_thresh);
  assign handshake = (state == ST_PUSH) && out_vld && out_rdy;

  // Anything arriving while a winner is waiting or during dead time is
  // lost, including a hit on the very clock the handshake completes.
  assign drop      = hit && ((state == ST_PUSH) || (state == ST_DEAD));

  // Next-state logic for the window FSM. The best register is only ever
  // replaced by a strictly higher priority, so on a tie the earliest
  // candidate in the window survives. Dropping enable wins over every state
  // and throws away the partially collected candidate; the drop counter is
  // left alone because it lives in its own block.
  always_comb begin
    state_nxt    = state;
    best_nxt     = best;
    bx_cnt_nxt   = bx_cnt;
    dead_cnt_nxt = dead_cnt;

    if (!enable) begin
      state_nxt    = ST_IDLE;
      best_nxt     = '0;
      bx_cnt_nxt   = '0;
      dead_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            best_nxt   = '{pri: clct_pri_best, win: clct_win_best, bx: 3'd0};
            bx_cnt_nxt = 3'd1;
            state_nxt  = (WIN_BX == 1) ? ST_PUSH : ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (hit && (clct_pri_best > best.pri)) begin
            best_nxt = '{pri: clct_pri_best, win: clct_win_best, bx: bx_cnt};
          end
          bx_cnt_nxt = bx_cnt + 3'd1;
          if (bx_cnt == LAST_BX) begin
            bx_cnt_nxt = '0;
            state_nxt  = ST_PUSH;
          end
        end

        ST_PUSH: begin
          if (handshake) begin
            best_nxt     = '0;
            dead_cnt_nxt = dead_time;
            state_nxt    = (dead_time != '0) ? ST_DEAD : ST_IDLE;
          end
        end

        ST_DEAD: begin
          dead_cnt_nxt = dead_cnt - DEAD_ONE;
          if (dead_cnt == DEAD_ONE) begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt    = ST_IDLE;
          best_nxt     = '0;
          bx_cnt_nxt   = '0;
          dead_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers. Outputs are computed from the next state so
  // that they change on the same edge as the FSM: the winner fields are
  // loaded as the FSM enters PUSH, held unchanged while out_rdy is low, and
  // returned to zero once the FSM leaves PUSH. Reset is asynchronous so the
  // outputs clear without waiting for a clock.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state    <= ST_IDLE;
      best     <= '0;
      bx_cnt   <= '0;
      dead_cnt <= '0;
      out_vld  <= 1'b0;
      out_win  <= '0;
      out_pri  <= '0;
      out_bx   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      best     <= best_nxt;
      bx_cnt   <= bx_cnt_nxt;
      dead_cnt <= dead_cnt_nxt;
      out_vld  <= (state_nxt == ST_PUSH);
      out_win  <= (state_nxt == ST_PUSH) ? best_nxt.win : '0;
      out_pri  <= (state_nxt == ST_PUSH) ? best_nxt.pri : '0;
      out_bx   <= (state_nxt == ST_PUSH) ? best_nxt.bx  : '0;
      busy     <= (state_nxt != ST_IDLE);
    end
  end

  // Dropped-hit counter; a clear on the same clock as a drop leaves zero
  clct_drop_counter #(
    .MXDROP(MXDROP)
  ) u_drop_counter (
    .clock       (clock),
    .global_reset(global_reset),
    .clr         (drop_clr),
    .inc         (drop),
    .cnt         (drop_cnt)
  );

endmodule
